// File: rtl/class_argmax_ctrl_pkg.sv
// class_argmax_ctrl_pkg: shared types and constants for the class argmax output stage.
// Contents: FSM state enum, default score width, most-negative score constant and helper.
package class_argmax_ctrl_pkg;
  localparam int FFN_OUT_BITWIDTH = 15;
  localparam int SCORE_W_DEF = FFN_OUT_BITWIDTH + 1;
  typedef enum logic [1:0] {IDLE, SCAN, VALID} state_t;
  function automatic logic [63:0] score_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
  localparam logic [SCORE_W_DEF-1:0] SCORE_MIN = SCORE_W_DEF'(score_min(SCORE_W_DEF));
endpackage

// File: rtl/class_argmax_ctrl_if.sv
// class_argmax_ctrl_if: score/result handshake bundle for class_argmax_ctrl.
// master: drives scores, product_rdy, result_ack; observes the result fields.
// slave:  the argmax stage; samples the inputs, drives class_idx, best_score,
//         margin, result_valid, busy, overrun.
interface class_argmax_ctrl_if
  import class_argmax_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES = 2,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
);
  logic [NUM_CLASSES*SCORE_W-1:0] scores;
  logic product_rdy;
  logic result_ack;
  logic [IDX_W-1:0] class_idx;
  logic [SCORE_W-1:0] best_score;
  logic [SCORE_W-1:0] margin;
  logic result_valid;
  logic busy;
  logic overrun;
  modport master (
    output scores, product_rdy, result_ack,
    input  class_idx, best_score, margin, result_valid, busy, overrun
  );
  modport slave (
    input  scores, product_rdy, result_ack,
    output class_idx, best_score, margin, result_valid, busy, overrun
  );
endinterface

// File: rtl/class_argmax_ctrl_hex_seg_decode.sv
// hex_seg_decode: combinational 4-bit to 7-segment decoder, active-low segments g..a.
// Ports: i_nib (hex digit), o_seg (segments, bit 6 = g, bit 0 = a, 0 = lit).
module hex_seg_decode (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  assign o_seg = SEG_LUT[i_nib];
endmodule

// File: rtl/class_argmax_ctrl.sv
// class_argmax_ctrl: snapshots NUM_CLASSES scores and scans them to find winner, score and margin.
// Ports: clock, reset (async active-low), bus (class_argmax_ctrl_if.slave).
// Optional: CLASS_ARGMAX_HEX_EN adds hex0, a registered 7-segment view of class_idx[3:0]
//           (active-low g..a, blank 7'h7F after reset).
module class_argmax_ctrl
  import class_argmax_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES = 2,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic clock,
  input  logic reset,
`ifdef CLASS_ARGMAX_HEX_EN
  output logic [6:0] hex0,
`endif
  class_argmax_ctrl_if.slave bus
);
  localparam logic [SCORE_W-1:0] SMIN = SCORE_W'(score_min(SCORE_W));
  state_t r_state;
  logic [NUM_CLASSES-1:0][SCORE_W-1:0] r_snap;
  logic signed [SCORE_W-1:0] r_best, r_second;
  logic [IDX_W-1:0] r_idx, r_ptr, r_class_idx;
  logic [SCORE_W-1:0] r_best_score, r_margin;
  logic r_valid, r_busy, r_overrun;
  logic signed [SCORE_W-1:0] w_s, w_best, w_second;
  logic [IDX_W-1:0] w_idx;
  logic w_gt_best, w_last, w_ack, w_cap, w_drop;
  assign w_s = r_snap[r_ptr];
  assign w_gt_best = w_s > r_best;
  assign w_best = w_gt_best ? w_s : r_best;
  assign w_second = w_gt_best ? r_best : (w_s > r_second ? w_s : r_second);
  assign w_idx = w_gt_best ? r_ptr : r_idx;
  assign w_last = r_ptr == IDX_W'(NUM_CLASSES - 1);
  assign w_ack = r_state == VALID && bus.result_ack;
  // A pulse is accepted in IDLE, or in VALID when the consumer acks in the same cycle.
  assign w_cap = bus.product_rdy && (r_state == IDLE || w_ack);
  assign w_drop = bus.product_rdy && !w_cap;
`ifdef CLASS_ARGMAX_HEX_EN
  logic [6:0] r_hex0, w_hex;
  hex_seg_decode u_hex (.i_nib(4'(w_idx)), .o_seg(w_hex));
  assign hex0 = r_hex0;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_snap <= '0;
      r_best <= '0;
      r_second <= '0;
      r_idx <= '0;
      r_ptr <= '0;
      r_class_idx <= '0;
      r_best_score <= '0;
      r_margin <= '0;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
      r_overrun <= 1'b0;
`ifdef CLASS_ARGMAX_HEX_EN
      r_hex0 <= 7'h7F;
`endif
    end else begin
      r_overrun <= w_drop | (r_overrun & ~w_ack);
      if (w_cap) begin
        r_snap <= bus.scores;
        r_best <= bus.scores[SCORE_W-1:0];
        r_second <= SMIN;
        r_idx <= '0;
        r_ptr <= IDX_W'(1);
        r_state <= SCAN;
        r_busy <= 1'b1;
        r_valid <= 1'b0;
      end else if (r_state == SCAN) begin
        r_best <= w_best;
        r_second <= w_second;
        r_idx <= w_idx;
        r_ptr <= r_ptr + 1'b1;
        if (w_last) begin
          r_state <= VALID;
          r_valid <= 1'b1;
          r_class_idx <= w_idx;
          r_best_score <= w_best;
          // best >= second always, so the true difference fits SCORE_W bits unsigned.
          r_margin <= w_best - w_second;
`ifdef CLASS_ARGMAX_HEX_EN
          r_hex0 <= w_hex;
`endif
        end
      end else if (w_ack) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end
  assign bus.class_idx = r_class_idx;
  assign bus.best_score = r_best_score;
  assign bus.margin = r_margin;
  assign bus.result_valid = r_valid;
  assign bus.busy = r_busy;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_class_argmax_ctrl.sv
// tb_class_argmax_ctrl: randomized self-checking bench for class_argmax_ctrl (N=4, 8-bit scores).
module tb_class_argmax_ctrl;
  import class_argmax_ctrl_pkg::*;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  class_argmax_ctrl_if #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(IW)) bus ();
`ifdef CLASS_ARGMAX_HEX_EN
  logic [6:0] hex0;
`endif
  class_argmax_ctrl #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(IW)) dut (
    .clock(clock),
    .reset(reset),
`ifdef CLASS_ARGMAX_HEX_EN
    .hex0(hex0),
`endif
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int sc[N];
  int e_idx, e_best, e_margin;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int hex_of(input int idx);
    case (idx)
      0: return 'h40;
      1: return 'h79;
      2: return 'h24;
      default: return 'h30;
    endcase
  endfunction
  task automatic model();
    int second;
    e_idx = 0;
    for (int i = 1; i < N; i++) if (sc[i] > sc[e_idx]) e_idx = i;
    e_best = sc[e_idx];
    second = -(1 << 30);
    for (int i = 0; i < N; i++) if (i != e_idx && sc[i] > second) second = sc[i];
    e_margin = e_best - second;
  endtask
  task automatic set4(input int a, input int b, input int c, input int d);
    sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d;
    model();
  endtask
  task automatic rand_scores();
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < N; i++)
      sc[i] = mode == 0 ? $urandom_range(0, 3) - 2 :
              mode == 1 ? ($urandom_range(0, 1) ? 127 : -128) :
              $urandom_range(0, 255) - 128;
    model();
  endtask
  task automatic drive_scores();
    for (int i = 0; i < N; i++) bus.scores[i*W +: W] = W'(sc[i]);
  endtask
  task automatic pulse();
    @(negedge clock);
    drive_scores();
    bus.product_rdy = 1'b1;
    @(negedge clock);
    bus.product_rdy = 1'b0;
    bus.scores = $urandom;
  endtask
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!bus.result_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask
  task automatic check_result(input string tag);
    chk({tag, "_valid"}, bus.result_valid, 1);
    chk({tag, "_idx"}, bus.class_idx, e_idx);
    chk({tag, "_best"}, $signed(bus.best_score), e_best);
    chk({tag, "_margin"}, bus.margin, e_margin);
`ifdef CLASS_ARGMAX_HEX_EN
    chk({tag, "_hex"}, hex0, hex_of(e_idx));
`endif
  endtask
  task automatic ack(input string tag);
    bus.result_ack = 1'b1;
    @(negedge clock);
    bus.result_ack = 1'b0;
    chk({tag, "_ack_valid"}, bus.result_valid, 0);
    chk({tag, "_ack_busy"}, bus.busy, 0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus.result_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
    chk({tag, "_idx"}, bus.class_idx, 0);
    chk({tag, "_best"}, bus.best_score, 0);
    chk({tag, "_margin"}, bus.margin, 0);
`ifdef CLASS_ARGMAX_HEX_EN
    chk({tag, "_hex"}, hex0, 'h7F);
`endif
  endtask
  initial begin
    bus.scores = '0;
    bus.product_rdy = 1'b0;
    bus.result_ack = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;
    set4(-10, 20, 15, 3);
    pulse();
    chk("basic_busy", bus.busy, 1);
    chk("basic_early_valid", bus.result_valid, 0);
    wait_valid("basic", N - 1);
    check_result("basic");
    repeat (2) @(negedge clock);
    check_result("basic_hold");
    ack("basic");
    set4(-10, 20, 15, 3);
    pulse();
    drive_scores();
    bus.scores = {4{8'd100}};
    bus.product_rdy = 1'b1;
    @(negedge clock);
    bus.product_rdy = 1'b0;
    chk("scan_drop_overrun", bus.overrun, 1);
    wait_valid("scan_drop", N - 2);
    check_result("scan_drop");
    ack("scan_drop");
    chk("scan_drop_cleared", bus.overrun, 0);
    set4(7, 7, 7, -1);
    pulse();
    wait_valid("tie", N - 1);
    check_result("tie");
    bus.product_rdy = 1'b1;
    @(negedge clock);
    bus.product_rdy = 1'b0;
    chk("valid_drop_overrun", bus.overrun, 1);
    check_result("valid_drop_hold");
    set4(-1, -2, -5, -9);
    drive_scores();
    bus.product_rdy = 1'b1;
    bus.result_ack = 1'b1;
    @(negedge clock);
    bus.product_rdy = 1'b0;
    bus.result_ack = 1'b0;
    bus.scores = '0;
    chk("b2b_valid", bus.result_valid, 0);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_overrun", bus.overrun, 0);
    wait_valid("b2b", N - 1);
    check_result("b2b");
    ack("b2b");
    bus.result_ack = 1'b1;
    @(negedge clock);
    bus.result_ack = 1'b0;
    chk("idle_ack_valid", bus.result_valid, 0);
    chk("idle_ack_busy", bus.busy, 0);
    set4(1, 2, 3, 4);
    pulse();
    reset = 1'b0;
    #1;
    check_zero("midscan_reset");
    @(negedge clock);
    reset = 1'b1;
    set4(3, 90, -4, 90);
    pulse();
    wait_valid("post_reset", N - 1);
    check_result("post_reset");
    ack("post_reset");
    for (int it = 0; it < 40; it++) begin
      rand_scores();
      pulse();
      if ($urandom_range(0, 1) == 1) begin
        bus.result_ack = 1'b1;
        @(negedge clock);
        bus.result_ack = 1'b0;
        wait_valid("rand_scanack", N - 2);
      end else begin
        wait_valid("rand", N - 1);
      end
      check_result("rand");
      repeat ($urandom_range(0, 3)) @(negedge clock);
      check_result("rand_hold");
      chk("rand_overrun", bus.overrun, 0);
      ack("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/class_argmax_ctrl.md
# class_argmax_ctrl

Output stage that sits directly downstream of the matrix-multiply stage of the network. On each `product_rdy` pulse it snapshots the `NUM_CLASSES` network output scores and scans them one per cycle to find the winning class, its score and its margin over the runner-up. It then holds the result under a valid/ack handshake for the display or host logic.

## Interface
- `NUM_CLASSES`, default 2: number of class scores. Must be ≥ 2.
- `SCORE_W`, default `FFN_OUT_BITWIDTH+1`: width of each score, two's complement signed.
- `IDX_W`, default `$clog2(NUM_CLASSES)` (min 1): width of the class index.
- `clock` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `scores` input, `NUM_CLASSES*SCORE_W` bits: class c occupies bits `[c*SCORE_W +: SCORE_W]`.
- `product_rdy` input, 1 bit: one-cycle pulse; `scores` are valid in that cycle only.
- `result_ack` input, 1 bit: consumer accepts the current result.
- `class_idx` output, `IDX_W` bits: index of the winning class.
- `best_score` output, `SCORE_W` bits: score of the winning class, signed.
- `margin` output, `SCORE_W` bits: best minus second-best, unsigned.
- `result_valid` output, 1 bit: result fields are stable and valid.
- `busy` output, 1 bit: high in SCAN and VALID.
- `overrun` output, 1 bit: sticky; a `product_rdy` pulse was dropped.

## Operation
- FSM states: IDLE, SCAN, VALID.
- **IDLE, `product_rdy`=1:**
  - Latch all scores into the snapshot bank.
  - best ← score[0], idx ← 0, second ← most-negative value (`1<<(SCORE_W-1)`), ptr ← 1.
  - Go to SCAN.
- **SCAN, each cycle, with s = snap[ptr]:**
  - If s > best (signed, strict): second ← best, best ← s, idx ← ptr.
  - Else if s > second: second ← s.
  - If ptr == NUM_CLASSES-1, go to VALID; otherwise ptr ← ptr+1.
- **Ties:** an equal score never displaces the current best, so the lowest index wins and the margin is 0.
- **Margin:** `margin = best - second`, computed in `SCORE_W+1` bits. The result is non-negative and fits in `SCORE_W` bits unsigned, so no saturation is needed.
- **Output registers:** `class_idx`, `best_score` and `margin` load on entry to VALID and hold until the next entry to VALID.
- **VALID:**
  - `result_valid`=1.
  - On `result_ack`=1, go to IDLE.
  - If `product_rdy`=1 in the same cycle as `result_ack`, perform the IDLE capture directly and go to SCAN; `result_valid` drops.
- **Overrun:** `product_rdy` in SCAN, or in VALID without `result_ack`, is dropped and sets `overrun`. `overrun` clears on the next accepted `result_ack`, unless a new drop happens in that same cycle.
- **`result_ack` outside VALID:** ignored.
- **Reset:** asserting `reset` in any state forces IDLE. All outputs go to 0: `class_idx`, `best_score`, `margin`, `result_valid`, `busy`, `overrun`. The snapshot bank is cleared.

## Timing
- Capture edge = E (edge where `product_rdy`=1 is accepted).
- `busy` rises after E.
- `result_valid` rises after edge E+NUM_CLASSES-1, i.e. a latency of NUM_CLASSES-1 cycles.
- `result_valid` stays high until the edge that samples `result_ack`=1.
- Minimum repeat interval with zero-wait ack is NUM_CLASSES cycles.
- `scores` are sampled only at E; later changes to `scores` have no effect.

## Configuration
- `CLASS_ARGMAX_HEX_EN` defined:
  - Adds output port `hex0` (7 bits, active-low segments g..a) showing `class_idx[3:0]` as a hex digit.
  - `hex0` is registered and updates on the same edge as `class_idx`.
  - Reset value is 7'h7F (blank) until the first result.
- Macro undefined: the `hex0` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package: the FSM state enum (IDLE/SCAN/VALID) and the `SCORE_MIN` constant (`1<<(SCORE_W-1)`).
- Sub-module `hex_seg_decode`: combinational 4-bit to 7-segment decoder, instantiated only under `CLASS_ARGMAX_HEX_EN`.
- The comparator/update datapath stays inline.

## Test plan
- **N=2, scores (5,−3), pulse at E:** `result_valid` at E+1; `class_idx`=0, `best_score`=5, `margin`=8; holds until `result_ack`.
- **N=2, tie (7,7):** `class_idx`=0, `margin`=0.
- **N=4, scores (−10,20,15,3):** `result_valid` at E+3; `class_idx`=1, `best_score`=20, `margin`=5.
- **N=4, second `product_rdy` one cycle after E:** dropped; `overrun`=1; result stays `class_idx`=1. Then `result_ack`: `overrun`=0, state IDLE.
- **`result_ack` and `product_rdy` in the same cycle in VALID, new scores (−1,−2):** `result_valid` falls one cycle, then rises with `class_idx`=0, `margin`=1.
- **`reset` low mid-SCAN:** all outputs 0 immediately; after release, a fresh pulse produces a correct result. With `CLASS_ARGMAX_HEX_EN`, `hex0`=7'h7F after reset and 7'h79 for `class_idx`=1.
